fft_in_reorder_pp: RTL and testbench

- Parametrised input bit-reversal reorder stage for the multi-mode FFT.
- Accepts natural-order complex samples under a valid/ready handshake and optionally conjugates them for inverse transforms.
- Writes each sample to bit-reversed addresses in one of two ping-pong buffer banks.
- Tracks bank occupancy against the downstream butterfly engine, which releases banks when it has finished with them.
- Frame size is selected at runtime, per frame, from LOG2_MIN..LOG2_MAX.

---
 rtl/fft_in_reorder_pp.sv | 236 +++++++++++++++++++++++
 tb/tb_fft_in_reorder_pp.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_in_reorder_pp.sv
// -----------------------------------------------------------------------------
// fft_in_reorder_pp
//
// Input bit-reversal reorder stage for the multi-mode FFT. Natural-order
// complex samples arrive under a valid/ready handshake. Each sample is written,
// one cycle later, to the bit-reversed address of its frame index in one of two
// ping-pong banks. Samples of inverse-transform frames are conjugated with a
// saturating negate of the imaginary part. The butterfly engine releases full
// banks in the order they were filled.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   input handshake; a sample is taken on in_valid & in_ready
//   sop_in               first sample of a frame (qualified by in_valid)
//   x_re, x_im           sample, DW-bit two's complement
//   inv, log2n           frame config, sampled with sop_in
//   wr_en, wr_bank,
//   wr_addr, wr_re,
//   wr_im                buffer write port (registered, one cycle after accept)
//   frame_done           pulse with the last write of a frame
//   done_bank,
//   frame_inv,
//   frame_log2n          completed-frame info, valid with frame_done
//   bank_full            per-bank occupancy
//   bank_release         pulse: downstream freed the oldest full bank
//   sop_err              pulse: sop arrived mid-frame, frame restarted
//   cfg_err              pulse: sop carried an illegal log2n, frame rejected
//
// State table
//   state | meaning
//   IDLE  | waiting for sop; ready only if the write bank is free
//   FILL  | collecting a frame into wbank; always ready
// -----------------------------------------------------------------------------
module fft_in_reorder_pp #(
    parameter int DW       = 16,
    parameter int LOG2_MAX = 9,
    parameter int LOG2_MIN = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                sop_in,
    input  logic [DW-1:0]       x_re,
    input  logic [DW-1:0]       x_im,
    input  logic                inv,
    input  logic [3:0]          log2n,
    output logic                in_ready,
    output logic                wr_en,
    output logic                wr_bank,
    output logic [LOG2_MAX-1:0] wr_addr,
    output logic [DW-1:0]       wr_re,
    output logic [DW-1:0]       wr_im,
    output logic                frame_done,
    output logic                done_bank,
    output logic                frame_inv,
    output logic [3:0]          frame_log2n,
    output logic [1:0]          bank_full,
    input  logic                bank_release,
    output logic                sop_err,
    output logic                cfg_err
);

    localparam int            AW    = LOG2_MAX;
    localparam logic [3:0]    L2MAX = 4'(LOG2_MAX);
    localparam logic [3:0]    L2MIN = 4'(LOG2_MIN);
    localparam logic [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [AW-1:0] ONE   = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Reverse all AW bits, then shift down so only the low lg bits of the
    // index land, reversed, in the low lg bits of the address.
    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] idx,
                                              input logic [3:0]    lg);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = idx[AW-1-i];
        end
        return r >> (L2MAX - lg);
    endfunction

    // Negating the most negative value would wrap; clamp it instead.
    function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] v);
        if (v == S_MIN) begin
            return S_MAX;
        end
        return -v;
    endfunction

    state_t        state;
    logic [AW-1:0] cnt;
    logic          wbank;
    logic          rbank;
    logic          ready_en;
    logic          cfg_inv;
    logic [3:0]    cfg_log2n;

    logic          acc;
    logic          lg_ok;
    logic [AW-1:0] last_idx;
    logic          is_last;
    logic [AW-1:0] addr_cnt;
    logic [DW-1:0] im_new;
    logic [DW-1:0] im_cur;
    logic          rel_ok;
    logic [1:0]    set_mask;
    logic [1:0]    clr_mask;

    // ready_en keeps in_ready low while reset is asserted.
    assign in_ready = ready_en & ((state == FILL) | ~bank_full[wbank]);
    assign acc      = in_valid & in_ready;
    assign lg_ok    = (log2n >= L2MIN) && (log2n <= L2MAX);
    assign last_idx = ~({AW{1'b1}} << cfg_log2n);
    assign is_last  = (cnt == last_idx);
    assign addr_cnt = bit_rev(cnt, cfg_log2n);

    // A sop sample uses the inv arriving with it; the rest use the latched one.
    assign im_new   = inv     ? neg_sat(x_im) : x_im;
    assign im_cur   = cfg_inv ? neg_sat(x_im) : x_im;

    // The completed bank is marked full at the end of the frame_done cycle.
    // Set and release both look at pre-cycle flags: the bank being set was
    // free at its sop, so a release can never target it in the same cycle.
    assign rel_ok   = bank_release & bank_full[rbank];
    assign set_mask = frame_done ? (done_bank ? 2'b10 : 2'b01) : 2'b00;
    assign clr_mask = rel_ok     ? (rbank     ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= 2'b00;
            rbank     <= 1'b0;
        end else begin
            bank_full <= (bank_full | set_mask) & ~clr_mask;
            if (rel_ok) begin
                rbank <= ~rbank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wbank       <= 1'b0;
            ready_en    <= 1'b0;
            cfg_inv     <= 1'b0;
            cfg_log2n   <= '0;
            wr_en       <= 1'b0;
            wr_bank     <= 1'b0;
            wr_addr     <= '0;
            wr_re       <= '0;
            wr_im       <= '0;
            frame_done  <= 1'b0;
            done_bank   <= 1'b0;
            frame_inv   <= 1'b0;
            frame_log2n <= '0;
            sop_err     <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            sop_err    <= 1'b0;
            cfg_err    <= 1'b0;

            case (state)
                IDLE: begin
                    // Samples without sop are dropped here.
                    if (acc && sop_in) begin
                        if (lg_ok) begin
                            cfg_log2n <= log2n;
                            cfg_inv   <= inv;
                            wr_en     <= 1'b1;
                            wr_bank   <= wbank;
                            wr_addr   <= '0;
                            wr_re     <= x_re;
                            wr_im     <= im_new;
                            cnt       <= ONE;
                            state     <= FILL;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    if (acc) begin
                        if (sop_in) begin
                            // Restart in the same bank; stale entries of the
                            // aborted frame get overwritten by the new one.
                            sop_err <= 1'b1;
                            if (lg_ok) begin
                                cfg_log2n <= log2n;
                                cfg_inv   <= inv;
                                wr_en     <= 1'b1;
                                wr_bank   <= wbank;
                                wr_addr   <= '0;
                                wr_re     <= x_re;
                                wr_im     <= im_new;
                                cnt       <= ONE;
                            end else begin
                                cfg_err <= 1'b1;
                                cnt     <= '0;
                                state   <= IDLE;
                            end
                        end else begin
                            wr_en   <= 1'b1;
                            wr_bank <= wbank;
                            wr_addr <= addr_cnt;
                            wr_re   <= x_re;
                            wr_im   <= im_cur;
                            if (is_last) begin
                                frame_done  <= 1'b1;
                                done_bank   <= wbank;
                                frame_inv   <= cfg_inv;
                                frame_log2n <= cfg_log2n;
                                wbank       <= ~wbank;
                                cnt         <= '0;
                                state       <= IDLE;
                            end else begin
                                cnt <= cnt + ONE;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_in_reorder_pp.sv
module tb_fft_in_reorder_pp;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        sop_in;
    logic [15:0] x_re;
    logic [15:0] x_im;
    logic        inv;
    logic [3:0]  log2n;
    logic        in_ready;
    logic        wr_en;
    logic        wr_bank;
    logic [8:0]  wr_addr;
    logic [15:0] wr_re;
    logic [15:0] wr_im;
    logic        frame_done;
    logic        done_bank;
    logic        frame_inv;
    logic [3:0]  frame_log2n;
    logic [1:0]  bank_full;
    logic        bank_release;
    logic        sop_err;
    logic        cfg_err;

    fft_in_reorder_pp #(.DW(16), .LOG2_MAX(9), .LOG2_MIN(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .sop_in       (sop_in),
        .x_re         (x_re),
        .x_im         (x_im),
        .inv          (inv),
        .log2n        (log2n),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_re        (wr_re),
        .wr_im        (wr_im),
        .frame_done   (frame_done),
        .done_bank    (done_bank),
        .frame_inv    (frame_inv),
        .frame_log2n  (frame_log2n),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .sop_err      (sop_err),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bank;
        logic [8:0]  addr;
        logic [15:0] re;
        logic [15:0] im;
        logic        done;
        logic        finv;
        logic [3:0]  flg;
    } wr_t;

    wr_t q[$];
    wr_t e_cur;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model (post-edge view)
    bit         m_en;
    bit         m_fill;
    int         m_cnt;
    logic [3:0] m_lg;
    logic       m_inv;
    logic       m_wbank;
    logic       m_rbank;
    logic [1:0] m_full;
    bit         m_pend;
    logic       m_pend_bank;
    logic       m_sop_err;
    logic       m_cfg_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [8:0] tb_rev(input int idx, input int lg);
        logic [8:0] r;
        r = '0;
        for (int b = 0; b < lg; b++) r[lg-1-b] = idx[b];
        return r;
    endfunction

    function automatic logic [15:0] tb_neg(input logic [15:0] v);
        int t;
        t = -int'($signed(v));
        if (t > 32767) t = 32767;
        return 16'(t);
    endfunction

    task automatic model_clear();
        m_en = 0; m_fill = 0; m_cnt = 0; m_lg = '0; m_inv = 0;
        m_wbank = 0; m_rbank = 0; m_full = 2'b00; m_pend = 0; m_pend_bank = 0;
        m_sop_err = 0; m_cfg_err = 0;
        q.delete();
    endtask

    // One cycle: called right after a negedge, returns at the next negedge.
    task automatic step(input logic v, input logic s, input logic [15:0] re,
                        input logic [15:0] im, input logic i, input logic [3:0] lg,
                        input logic rel);
        logic       exp_rdy;
        logic       acc;
        logic       legal;
        logic       rel_ok;
        logic [1:0] nf;
        wr_t        w;
        in_valid = v; sop_in = s; x_re = re; x_im = im; inv = i; log2n = lg;
        bank_release = rel;
        exp_rdy = m_en & (m_fill | ~m_full[m_wbank]);
        #1;
        chk("in_ready", in_ready, exp_rdy);
        acc    = v & exp_rdy;
        legal  = (lg >= 4'd6) && (lg <= 4'd9);
        rel_ok = rel & m_full[m_rbank];
        nf = m_full;
        if (m_pend) nf[m_pend_bank] = 1'b1;
        if (rel_ok) begin
            nf[m_rbank] = 1'b0;
            m_rbank = ~m_rbank;
        end
        m_pend = 0; m_sop_err = 0; m_cfg_err = 0;
        if (acc) begin
            if (s) begin
                if (m_fill) m_sop_err = 1;
                if (legal) begin
                    m_lg = lg; m_inv = i;
                    w = '{m_wbank, 9'd0, re, (i ? tb_neg(im) : im), 1'b0, 1'b0, 4'd0};
                    q.push_back(w);
                    m_cnt = 1; m_fill = 1;
                end else begin
                    m_cfg_err = 1; m_fill = 0; m_cnt = 0;
                end
            end else if (m_fill) begin
                w.bank = m_wbank;
                w.addr = tb_rev(m_cnt, int'(m_lg));
                w.re   = re;
                w.im   = m_inv ? tb_neg(im) : im;
                w.done = (m_cnt == (1 << m_lg) - 1);
                w.finv = m_inv;
                w.flg  = m_lg;
                q.push_back(w);
                if (w.done) begin
                    m_pend = 1; m_pend_bank = m_wbank;
                    m_wbank = ~m_wbank; m_fill = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        m_full = nf;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 16'h0, 16'h0, 0, 4'd6, 0);
    endtask

    task automatic release_bank();
        step(0, 0, 16'h0, 16'h0, 0, 4'd6, 1);
    endtask

    task automatic run_frame(input logic [3:0] lg, input logic i, input int n, input bit gap);
        for (int k = 0; k < n; k++) begin
            step(1, k == 0, 16'(k), 16'(-k), i, lg, 0);
            if (gap) step(0, 0, 16'hdead, 16'hbeef, 0, lg, 0);
        end
    endtask

    task automatic do_reset();
        #2;
        in_valid = 0; sop_in = 0; bank_release = 0; x_re = '0; x_im = '0; inv = 0; log2n = '0;
        rst_n = 0;
        model_clear();
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_re", wr_re, 0);
        chk("rst_wr_im", wr_im, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_done_bank", done_bank, 0);
        chk("rst_frame_inv", frame_inv, 0);
        chk("rst_frame_log2n", frame_log2n, 0);
        chk("rst_bank_full", bank_full, 0);
        chk("rst_sop_err", sop_err, 0);
        chk("rst_cfg_err", cfg_err, 0);
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        m_en = 1;
    endtask

    // Output monitor / scoreboard pop.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (q.size() == 0) begin
                    chk("unexpected_wr", 1, 0);
                end else begin
                    e_cur = q.pop_front();
                    chk("wr_bank", wr_bank, e_cur.bank);
                    chk("wr_addr", wr_addr, e_cur.addr);
                    chk("wr_re", wr_re, e_cur.re);
                    chk("wr_im", wr_im, e_cur.im);
                    chk("frame_done", frame_done, e_cur.done);
                    if (e_cur.done) begin
                        chk("done_bank", done_bank, e_cur.bank);
                        chk("frame_inv", frame_inv, e_cur.finv);
                        chk("frame_log2n", frame_log2n, e_cur.flg);
                    end
                end
            end else begin
                chk("frame_done_nowr", frame_done, 0);
                if (q.size() != 0) begin
                    chk("missing_wr", q.size(), 0);
                    void'(q.pop_front());
                end
            end
            chk("sop_err", sop_err, m_sop_err);
            chk("cfg_err", cfg_err, m_cfg_err);
            chk("bank_full", bank_full, m_full);
        end
    end

    initial begin
        rst_n = 0;
        in_valid = 0; sop_in = 0; bank_release = 0; x_re = '0; x_im = '0; inv = 0; log2n = '0;
        model_clear();
        @(negedge clk);
        do_reset();

        // 64-point forward frame into bank 0
        run_frame(4'd6, 0, 64, 0);
        idle(2);

        // 512-point inverse frame into bank 1, saturation corner at index 1
        for (int k = 0; k < 512; k++) begin
            logic [15:0] re_v;
            logic [15:0] im_v;
            re_v = 16'($urandom);
            im_v = (k == 1) ? 16'h8000 : (k == 2) ? 16'd5 : 16'($urandom);
            step(1, k == 0, re_v, im_v, 1, 4'd9, 0);
        end
        idle(2);
        release_bank();
        release_bank();
        release_bank();   // nothing full: ignored
        idle(1);

        // 128-point frame with a restart at index 40
        run_frame(4'd7, 0, 40, 0);
        run_frame(4'd7, 0, 128, 0);
        idle(2);
        release_bank();
        idle(1);

        // back-to-back frames fill both banks; third sop held off
        run_frame(4'd6, 0, 64, 0);
        run_frame(4'd6, 0, 64, 0);
        idle(1);
        for (int k = 0; k < 3; k++) step(1, 1, 16'h1111, 16'h2222, 0, 4'd6, 0);
        step(1, 1, 16'h1111, 16'h2222, 0, 4'd6, 1);
        run_frame(4'd6, 0, 64, 0);
        release_bank();   // coincides with the full-flag set of the frame just done
        idle(1);
        release_bank();
        idle(1);

        // illegal sizes and stray samples
        step(1, 1, 16'h0001, 16'h0002, 0, 4'd10, 0);
        step(1, 1, 16'h0003, 16'h0004, 0, 4'd5, 0);
        step(1, 0, 16'h0005, 16'h0006, 0, 4'd6, 0);
        idle(1);
        run_frame(4'd6, 0, 10, 0);
        step(1, 1, 16'h0007, 16'h0008, 0, 4'd15, 0);
        step(1, 0, 16'h0009, 16'h000a, 0, 4'd6, 0);
        idle(2);

        // gapped inverse frame, then reset in the middle of the next one
        run_frame(4'd6, 1, 64, 1);
        idle(1);
        run_frame(4'd6, 0, 30, 0);
        do_reset();
        run_frame(4'd6, 0, 64, 0);
        idle(3);

        chk("leftover_expected", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
